// File: rtl/drone_speed_ctrl.sv
// drone_speed_ctrl: sequences the 2-bit saturating speed-level counter.
// Arbitrates between manual up/down buttons, a remote load channel
// (req/ack), and an emergency request that ramps the level down to zero.
// Every output is a flop decoded from the current state, so each command
// appears one cycle after the state that issues it.
// Optional feature macro: DRONE_AUTOREPEAT_EN. When defined, a single button
// held in IDLE repeats its step every REPEAT_TICKS cycles.
module drone_speed_ctrl #(
  parameter int unsigned RAMP_TICKS   = 50000000,
  parameter int unsigned REPEAT_TICKS = 25000000,
  parameter int unsigned TIMER_W      = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       rem_req,
  input  logic [1:0] rem_val,
  output logic       rem_ack,
  input  logic       emerg,
  input  logic [1:0] cnt_q,
  output logic       cnt_clr_n,
  output logic       cnt_ld_n,
  output logic [1:0] cnt_d,
  output logic       cnt_enp,
  output logic       cnt_soma,
  output logic       cnt_sub,
  output logic       landing,
  output logic       landed
);

  typedef enum logic [3:0] {
    S_CLR, S_IDLE, S_STEP_UP, S_STEP_DN, S_LOAD, S_ACK, S_REL,
    S_RAMP_WAIT, S_RAMP_STEP, S_LANDED
  } state_e;

  localparam logic [TIMER_W-1:0] RAMP_RELOAD = TIMER_W'(RAMP_TICKS - 1);
`ifdef DRONE_AUTOREPEAT_EN
  localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_TICKS - 1);
`endif

  // Refuse to elaborate a timer too narrow for the configured tick counts.
  if ((RAMP_TICKS < 2) || (((RAMP_TICKS - 1) >> TIMER_W) != 0) ||
      (((REPEAT_TICKS - 1) >> TIMER_W) != 0)) begin : g_bad_timer_cfg
    $error("drone_speed_ctrl: RAMP_TICKS < 2 or TIMER_W too narrow");
  end

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               up_prev_q, up_prev_d, dn_prev_q, dn_prev_d;
  logic               clr_n_q, clr_n_d, ld_n_q, ld_n_d;
  logic               enp_q, enp_d, soma_q, soma_d, sub_q, sub_d;
  logic [1:0]         cd_q, cd_d;
  logic               ack_q, ack_d, landing_q, landing_d, landed_q, landed_d;
  logic               up_rise, dn_rise;

  assign up_rise = btn_up & ~up_prev_q;
  assign dn_rise = btn_down & ~dn_prev_q;

  // Next-state, timer and edge-register logic.
  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    up_prev_d = btn_up;
    dn_prev_d = btn_down;
    case (state_q)
      S_CLR: state_d = S_IDLE;
      S_IDLE: begin
        if (emerg) begin
          state_d = S_RAMP_WAIT;
          timer_d = RAMP_RELOAD;
        end else if (rem_req) begin
          state_d = S_LOAD;
        end else if (up_rise && !dn_rise) begin
          state_d = S_STEP_UP;
        end else if (dn_rise && !up_rise) begin
          state_d = S_STEP_DN;
        end
`ifdef DRONE_AUTOREPEAT_EN
        // Count only while exactly one button is held and nothing changed.
        else if ((btn_up ^ btn_down) && (btn_up == up_prev_q) &&
                 (btn_down == dn_prev_q)) begin
          if (timer_q == REPEAT_LAST) state_d = btn_up ? S_STEP_UP : S_STEP_DN;
          else                        timer_d = timer_q + 1'b1;
        end
`endif
      end
      S_STEP_UP, S_STEP_DN: state_d = S_IDLE;
      S_LOAD: state_d = S_ACK;
      S_ACK:  state_d = S_REL;
      S_REL: begin
        if (emerg) begin
          state_d = S_RAMP_WAIT;
          timer_d = RAMP_RELOAD;
        end else if (!rem_req) begin
          state_d = S_IDLE;
        end
      end
      S_RAMP_WAIT: begin
        if (timer_q == '0) state_d = (cnt_q == 2'b00) ? S_LANDED : S_RAMP_STEP;
        else               timer_d = timer_q - 1'b1;
      end
      S_RAMP_STEP: begin
        state_d = S_RAMP_WAIT;
        timer_d = RAMP_RELOAD;
      end
      S_LANDED: if (!emerg) state_d = S_CLR;
      default:  state_d = S_CLR;
    endcase
  end

  // Output decode of the current state, registered below.
  always_comb begin
    clr_n_d   = (state_q != S_CLR);
    ld_n_d    = (state_q != S_LOAD);
    cd_d      = (state_q == S_LOAD) ? rem_val : 2'b00;
    enp_d     = (state_q == S_STEP_UP) || (state_q == S_STEP_DN) ||
                (state_q == S_RAMP_STEP);
    soma_d    = (state_q == S_STEP_UP);
    sub_d     = (state_q == S_STEP_DN) || (state_q == S_RAMP_STEP);
    ack_d     = (state_q == S_ACK);
    landing_d = (state_q == S_RAMP_WAIT) || (state_q == S_RAMP_STEP);
    landed_d  = (state_q == S_LANDED);
  end

  // State, timer, edge and output flops with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_CLR;
      timer_q   <= '0;
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
      clr_n_q   <= 1'b1;
      ld_n_q    <= 1'b1;
      cd_q      <= 2'b00;
      enp_q     <= 1'b0;
      soma_q    <= 1'b0;
      sub_q     <= 1'b0;
      ack_q     <= 1'b0;
      landing_q <= 1'b0;
      landed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      up_prev_q <= up_prev_d;
      dn_prev_q <= dn_prev_d;
      clr_n_q   <= clr_n_d;
      ld_n_q    <= ld_n_d;
      cd_q      <= cd_d;
      enp_q     <= enp_d;
      soma_q    <= soma_d;
      sub_q     <= sub_d;
      ack_q     <= ack_d;
      landing_q <= landing_d;
      landed_q  <= landed_d;
    end
  end

  assign cnt_clr_n = clr_n_q;
  assign cnt_ld_n  = ld_n_q;
  assign cnt_d     = cd_q;
  assign cnt_enp   = enp_q;
  assign cnt_soma  = soma_q;
  assign cnt_sub   = sub_q;
  assign rem_ack   = ack_q;
  assign landing   = landing_q;
  assign landed    = landed_q;

endmodule

// File: tb/tb_drone_speed_ctrl.sv
// Bench for drone_speed_ctrl: drives a model of the 2-bit counter from the
// DUT commands, then checks table vectors, random button/load traffic against
// a level-tracking model, and cycle-exact corner sequences.
module tb_drone_speed_ctrl;
  localparam int RT = 4;

  logic       clock = 1'b0, reset = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, rem_req = 1'b0, emerg = 1'b0;
  logic [1:0] rem_val = 2'b00;
  logic       rem_ack, cnt_clr_n, cnt_ld_n, cnt_enp, cnt_soma, cnt_sub;
  logic       landing, landed;
  logic [1:0] cnt_d;
  logic [1:0] lvl = 2'd2;

  int n_cmp = 0, n_bad = 0;
  int n_up = 0, n_dn = 0, n_ld = 0, n_ack = 0;

  drone_speed_ctrl #(.RAMP_TICKS(RT), .REPEAT_TICKS(8), .TIMER_W(8)) dut (
    .clock(clock), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .rem_req(rem_req), .rem_val(rem_val), .rem_ack(rem_ack), .emerg(emerg),
    .cnt_q(lvl), .cnt_clr_n(cnt_clr_n), .cnt_ld_n(cnt_ld_n), .cnt_d(cnt_d),
    .cnt_enp(cnt_enp), .cnt_soma(cnt_soma), .cnt_sub(cnt_sub),
    .landing(landing), .landed(landed)
  );

  always #5 clock = ~clock;

  // Saturating up/down counter the controller drives.
  always @(posedge clock) begin
    if (!cnt_clr_n)     lvl <= 2'd0;
    else if (!cnt_ld_n) lvl <= cnt_d;
    else if (cnt_enp) begin
      if (cnt_soma && lvl != 2'd3)     lvl <= lvl + 2'd1;
      else if (cnt_sub && lvl != 2'd0) lvl <= lvl - 2'd1;
    end
  end

  always @(posedge clock) begin
    if (cnt_enp && cnt_soma) n_up  <= n_up + 1;
    if (cnt_enp && cnt_sub)  n_dn  <= n_dn + 1;
    if (!cnt_ld_n)           n_ld  <= n_ld + 1;
    if (rem_ack)             n_ack <= n_ack + 1;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(2); reset = 1'b0; tick(3);
  endtask

  task automatic press(input bit u, input bit d, input int hold);
    btn_up = u; btn_down = d; tick(hold);
    btn_up = 1'b0; btn_down = 1'b0; tick(3);
  endtask

  task automatic load(input logic [1:0] v);
    bit got = 0;
    rem_val = v; rem_req = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      tick(1);
      if (rem_ack) got = 1;
    end
    chk("load_ack_seen", int'(got), 1);
    rem_req = 1'b0; tick(3);
  endtask

  typedef struct { int op; logic [1:0] val; logic [1:0] exp; } vec_t;
  vec_t tbl[11];

  initial begin
    int s_up, s_dn, s_ld, s_ack, mlvl, op, first_land, first_landed, land_cnt;
    logic [1:0] v;
    int subs[$];
    int acks[$];
    int landed_at[$];

    // ops: 0 up, 1 down, 2 both, 3 remote load
    tbl[0]  = '{0, 2'd0, 2'd1}; tbl[1]  = '{0, 2'd0, 2'd2};
    tbl[2]  = '{0, 2'd0, 2'd3}; tbl[3]  = '{0, 2'd0, 2'd3};
    tbl[4]  = '{2, 2'd0, 2'd3}; tbl[5]  = '{3, 2'd1, 2'd1};
    tbl[6]  = '{1, 2'd0, 2'd0}; tbl[7]  = '{1, 2'd0, 2'd0};
    tbl[8]  = '{2, 2'd0, 2'd0}; tbl[9]  = '{3, 2'd2, 2'd2};
    tbl[10] = '{1, 2'd0, 2'd1};

    // Reset: outputs inactive while held, one clr pulse after release.
    tick(2);
    chk("reset_outputs", int'({cnt_clr_n, cnt_ld_n, cnt_enp, cnt_soma, cnt_sub,
        cnt_d, rem_ack, landing, landed}), int'(10'b1100000000));
    reset = 1'b0; tick(1);
    chk("release_clr_pulse", int'({cnt_clr_n, cnt_ld_n, cnt_enp, cnt_d, rem_ack,
        landing, landed}), int'(8'b01000000));
    tick(1);
    chk("after_clr_idle", int'({cnt_clr_n, cnt_ld_n, cnt_enp}), int'(3'b110));
    tick(1);
    chk("reset_clears_level", int'(lvl), 0);

    // Single step timing from level 1: pulse two cycles after the edge.
    press(1, 0, 1);
    chk("first_up_level", int'(lvl), 1);
    s_up = n_up;
    btn_up = 1'b1; tick(1);
    chk("up_edge_plus1_enp", int'(cnt_enp), 0);
    tick(1);
    chk("up_edge_plus2_enp_soma", int'({cnt_enp, cnt_soma, cnt_sub}), int'(3'b110));
    tick(1);
    chk("up_pulse_one_cycle", int'(cnt_enp), 0);
    chk("up_level_01_to_10", int'(lvl), 2);
    tick(20);
    chk("hold_no_repeat", n_up - s_up, 1);
    btn_up = 1'b0; tick(3);

    // Simultaneous rising edges are ignored.
    s_up = n_up; s_dn = n_dn;
    btn_up = 1'b1; btn_down = 1'b1; tick(6);
    btn_up = 1'b0; btn_down = 1'b0; tick(3);
    chk("both_no_pulse", (n_up - s_up) + (n_dn - s_dn), 0);
    chk("both_level_kept", int'(lvl), 2);

    // Remote load, exact handshake timing.
    s_ld = n_ld; s_ack = n_ack;
    rem_val = 2'b10; rem_req = 1'b1; tick(1);
    chk("load_not_yet", int'(cnt_ld_n), 1);
    tick(1);
    chk("load_pulse", int'({cnt_ld_n, cnt_d}), int'(3'b010));
    tick(1);
    chk("ack_pulse", int'({cnt_ld_n, rem_ack}), int'(2'b11));
    tick(1);
    chk("ack_one_cycle", int'(rem_ack), 0);
    tick(6);
    chk("single_load_while_held", n_ld - s_ld, 1);
    chk("single_ack_while_held", n_ack - s_ack, 1);
    rem_req = 1'b0; tick(2);
    load(2'b01);
    chk("second_load_after_rerise", n_ld - s_ld, 2);
    chk("second_load_level", int'(lvl), 1);

    // Table-driven vectors from a fresh reset.
    do_reset();
    foreach (tbl[i]) begin
      case (tbl[i].op)
        0: press(1, 0, 2);
        1: press(0, 1, 2);
        2: press(1, 1, 2);
        default: load(tbl[i].val);
      endcase
      chk("tbl_level", int'(lvl), int'(tbl[i].exp));
    end

    // Random traffic against a level model.
    do_reset();
    mlvl = 0;
    for (int n = 0; n < 120; n++) begin
      op = $urandom_range(0, 3);
      v  = 2'($urandom_range(0, 3));
      s_ack = n_ack;
      case (op)
        0: begin press(1, 0, $urandom_range(1, 5)); mlvl = (mlvl < 3) ? mlvl + 1 : 3; end
        1: begin press(0, 1, $urandom_range(1, 5)); mlvl = (mlvl > 0) ? mlvl - 1 : 0; end
        2: press(1, 1, $urandom_range(1, 5));
        default: begin load(v); mlvl = int'(v); chk("rnd_ack_count", n_ack - s_ack, 1); end
      endcase
      chk("rnd_level", int'(lvl), mlvl);
    end

    // Emergency ramp from level 3 with button noise.
    load(2'd3);
    chk("ramp_start_level", int'(lvl), 3);
    emerg = 1'b1; first_land = -1; first_landed = -1; land_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      btn_down = (i >= 3 && i <= 15) ? i[0] : 1'b0;
      tick(1);
      if (cnt_enp && cnt_sub) subs.push_back(i);
      if (landing) begin land_cnt++; if (first_land < 0) first_land = i; end
      if (landed && first_landed < 0) first_landed = i;
    end
    chk("ramp_sub_count", subs.size(), 3);
    if (subs.size() == 3) begin
      chk("ramp_sub0_at", subs[0], 2 + RT);
      chk("ramp_sub1_at", subs[1], 2 + 2 * RT + 1);
      chk("ramp_sub2_at", subs[2], 2 + 3 * RT + 2);
    end
    chk("landing_first", first_land, 2);
    chk("landing_length", land_cnt, 19);
    chk("landed_first", first_landed, 21);
    chk("landed_held", int'(landed), 1);
    chk("ramp_level_zero", int'(lvl), 0);
    emerg = 1'b0; tick(1);
    chk("landed_until_clr", int'({landed, cnt_clr_n}), int'(2'b11));
    tick(1);
    chk("recover_clr_pulse", int'({landed, cnt_clr_n}), int'(2'b00));
    tick(1);
    chk("recover_idle", int'({cnt_clr_n, landing, landed}), int'(3'b100));

    // Emergency during ACK; remote request still pending after recovery.
    subs.delete();
    rem_val = 2'd2; rem_req = 1'b1; tick(2);
    chk("pre_emerg_load", int'({cnt_ld_n, cnt_d}), int'(3'b010));
    emerg = 1'b1;
    for (int i = 3; i <= 30; i++) begin
      if (i == 6) emerg = 1'b0;
      btn_down = (i >= 5 && i <= 14) ? i[0] : 1'b0;
      tick(1);
      if (cnt_enp && cnt_sub) subs.push_back(i);
      if (rem_ack) acks.push_back(i);
      if (landed) landed_at.push_back(i);
    end
    chk("acked_sub_count", subs.size(), 2);
    if (subs.size() == 2) begin
      chk("acked_sub0_at", subs[0], 9);
      chk("acked_sub1_at", subs[1], 14);
    end
    chk("acked_ack_count", acks.size(), 2);
    if (acks.size() == 2) begin
      chk("ack_before_ramp_at", acks[0], 3);
      chk("ack_after_recover_at", acks[1], 23);
    end
    chk("acked_landed_count", landed_at.size(), 1);
    chk("pending_load_served", int'(lvl), 2);
    rem_req = 1'b0; tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
